ram_loader_mar: RTL

- Stage directly upstream of the 16x8 RAM; drives the RAM's address, write-data and write-enable inputs.
- Run mode (ProgMode=0): acts as the Memory Address Register (MAR). It latches the low nibble of the bus on MARIn and presents it as the RAM address.
- Program mode (ProgMode=1): acts as a loader. It accepts a byte stream over a valid/ready handshake and writes it into RAM addresses 0..DEPTH-1 in order, then reports done.

---
 rtl/ram_loader_mar.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ram_loader_mar.sv
// Front end of the 16x8 RAM: memory address register in run mode, sequential
// byte loader (valid/ready in, RAM write strobes out) in program mode.
module ram_loader_mar #(
  parameter int unsigned AW           = 4,
  parameter int unsigned DW           = 8,
  parameter int unsigned WRITE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] BusIn,
  input  logic          MARIn,
  input  logic          ProgMode,
  input  logic [DW-1:0] LdData,
  input  logic          LdValid,
  output logic          LdReady,
  output logic          LdDone,
  output logic [AW-1:0] Addrs,
  output logic [DW-1:0] RAMData,
  output logic          RAMIn,
  output logic          Busy
);

  typedef enum logic [1:0] {StRun, StLoad, StWrite, StDone} state_e;

  localparam logic [1:0] WcLast = 2'(WRITE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addrs_q, addrs_d;
  logic [DW-1:0] ram_data_q, ram_data_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic          ram_in_q, ram_in_d;
  logic          ld_ready_q, ld_ready_d;
  logic          ld_done_q, ld_done_d;
  logic          busy_q, busy_d;
  logic          handshake;
  logic          last_write;

  assign handshake  = LdValid & ld_ready_q;
  assign last_write = (wcnt_q == WcLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      ptr_q      <= '0;
      addrs_q    <= '0;
      ram_data_q <= '0;
      wcnt_q     <= '0;
      ram_in_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addrs_q    <= addrs_d;
      ram_data_q <= ram_data_d;
      wcnt_q     <= wcnt_d;
      ram_in_q   <= ram_in_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      busy_q     <= busy_d;
    end
  end

  // Dropping ProgMode aborts LOAD/DONE at once, but WRITE only after its full pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (ProgMode) state_d = StLoad;
      StLoad: begin
        if (!ProgMode)      state_d = StRun;
        else if (handshake) state_d = StWrite;
      end
      StWrite: begin
        if (last_write) begin
          if (!ProgMode)         state_d = StRun;
          else if (ptr_q == '1)  state_d = StDone;
          else                   state_d = StLoad;
        end
      end
      StDone:  if (!ProgMode) state_d = StRun;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    addrs_d    = addrs_q;
    ram_data_d = ram_data_q;
    wcnt_d     = wcnt_q;
    unique case (state_q)
      StRun: begin
        if (ProgMode)   ptr_d   = '0;
        else if (MARIn) addrs_d = BusIn[AW-1:0];
      end
      StLoad: begin
        if (ProgMode && handshake) begin
          ram_data_d = LdData;
          addrs_d    = ptr_q;
          wcnt_d     = '0;
        end
      end
      StWrite: begin
        wcnt_d = wcnt_q + 2'd1;
        if (last_write && ProgMode && ptr_q != '1) ptr_d = ptr_q + 1'b1;
      end
      StDone: ;
    endcase
    // Any return to run mode from a loader state parks the address at 0.
    if (state_q != StRun && state_d == StRun) addrs_d = '0;

    ram_in_d   = (state_d == StWrite);
    ld_ready_d = (state_d == StLoad);
    ld_done_d  = (state_d == StDone);
    busy_d     = (state_d != StRun);
  end

  assign LdReady = ld_ready_q;
  assign LdDone  = ld_done_q;
  assign Addrs   = addrs_q;
  assign RAMData = ram_data_q;
  assign RAMIn   = ram_in_q;
  assign Busy    = busy_q;

endmodule
